// File: rtl/spart_pkg.sv
// Shared constants for the SPART processor front end: bus addresses, status layout,
// standard baud divisors and transmit-handshake state encodings.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam int STAT_TBR = 0;
    localparam int STAT_RDA = 1;
    localparam int STAT_OVR = 2;

    // Divisors for 16x oversampling from a 100 MHz clock
    localparam logic [15:0] DIV_4800  = 16'h0516;
    localparam logic [15:0] DIV_9600  = 16'h028B;
    localparam logic [15:0] DIV_19200 = 16'h0145;
    localparam logic [15:0] DIV_38400 = 16'h00A3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_WAIT  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/spart_baud_gen.sv
// 16x baud enable generator: a down counter that pulses baud_en_o once every divisor clocks.
// A load strobe restarts the count from the new divisor at the same edge.
module spart_baud_gen #(
    parameter int                CNT_W       = 16,
    parameter logic [CNT_W-1:0]  DEFAULT_DIV = CNT_W'(16'h028B)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] div_i,
    input  logic             load_i,
    output logic             baud_en_o
);

    // Divisors of 0 and 1 both collapse to a reload of 0, i.e. a pulse every cycle
    localparam logic [CNT_W-1:0] RST_CNT =
        (DEFAULT_DIV <= CNT_W'(1)) ? '0 : DEFAULT_DIV - CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] reload;

    always_comb begin
        reload = (div_i <= CNT_W'(1)) ? '0 : div_i - CNT_W'(1);
        cnt_d  = cnt_q;
        if (load_i || (cnt_q == '0)) begin
            cnt_d = reload;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_CNT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign baud_en_o = (cnt_q == '0);

endmodule

// File: rtl/spart_bus_baud.sv
// Processor-facing SPART front end: bus register decode, receive/transmit holding registers,
// transmitter start/busy handshake and the programmable baud divisor.
module spart_bus_baud
    import spart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = DIV_9600,
    parameter int          CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       baud_en
);

    tx_state_e        txState_q, txState_d;
    logic             waitCnt_q, waitCnt_d;
    logic             tbr_q, tbr_d;
    logic             rda_q, rda_d;
    logic             ovr_q, ovr_d;
    logic [7:0]       rxBuf_q, rxBuf_d;
    logic [7:0]       txHold_q, txHold_d;
    logic [7:0]       divLow_q, divLow_d;
    logic [CNT_W-1:0] div_q, div_d;

    logic       busRead;
    logic       busWrite;
    logic       rdBuf;
    logic       wrBuf;
    logic       wrDbl;
    logic       wrDbh;
    logic [7:0] readData;

    assign busRead  = iocs & iorw;
    assign busWrite = iocs & ~iorw;
    assign rdBuf    = busRead  & (ioaddr == ADDR_BUF);
    assign wrBuf    = busWrite & (ioaddr == ADDR_BUF);
    assign wrDbl    = busWrite & (ioaddr == ADDR_DBL);
    assign wrDbh    = busWrite & (ioaddr == ADDR_DBH);

    always_comb begin
        readData = 8'h00;
        case (ioaddr)
            ADDR_BUF:  readData = rxBuf_q;
            ADDR_STAT: begin
                readData[STAT_TBR] = tbr_q;
                readData[STAT_RDA] = rda_q;
                readData[STAT_OVR] = ovr_q;
            end
            ADDR_DBL:  readData = div_q[7:0];
            default:   readData = div_q[15:8];
        endcase
    end

    assign databus = busRead ? readData : 8'hzz;

    // Next-state logic for the tx handshake FSM, rx buffer and divisor registers
    always_comb begin
        txState_d = txState_q;
        waitCnt_d = waitCnt_q;
        tbr_d     = tbr_q;
        rda_d     = rda_q;
        ovr_d     = ovr_q;
        rxBuf_d   = rxBuf_q;
        txHold_d  = txHold_q;
        divLow_d  = divLow_q;
        div_d     = div_q;
        tx_start  = 1'b0;

        case (txState_q)
            TX_IDLE: begin
                if (!tbr_q && !tx_busy) begin
                    txState_d = TX_START;
                end
            end
            TX_START: begin
                tx_start  = 1'b1;
                tbr_d     = 1'b1;
                waitCnt_d = 1'b0;
                txState_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_busy || waitCnt_q) begin
                    txState_d = TX_IDLE;
                end else begin
                    waitCnt_d = 1'b1;
                end
            end
            default: txState_d = TX_IDLE;
        endcase

        // The holding register is free again in the start cycle, so back-to-back writes land
        if (wrBuf && (tbr_q || (txState_q == TX_START))) begin
            txHold_d = databus;
            tbr_d    = 1'b0;
        end

        if (rx_valid) begin
            rxBuf_d = rx_data;
            rda_d   = 1'b1;
            ovr_d   = rdBuf ? 1'b0 : (ovr_q | rda_q);
        end else if (rdBuf) begin
            rda_d = 1'b0;
            ovr_d = 1'b0;
        end

        if (wrDbl) begin
            divLow_d = databus;
        end
        if (wrDbh) begin
            div_d = {databus, divLow_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txState_q <= TX_IDLE;
            waitCnt_q <= 1'b0;
            tbr_q     <= 1'b1;
            rda_q     <= 1'b0;
            ovr_q     <= 1'b0;
            rxBuf_q   <= 8'h00;
            txHold_q  <= 8'h00;
            divLow_q  <= DEFAULT_DIV[7:0];
            div_q     <= DEFAULT_DIV;
        end else begin
            txState_q <= txState_d;
            waitCnt_q <= waitCnt_d;
            tbr_q     <= tbr_d;
            rda_q     <= rda_d;
            ovr_q     <= ovr_d;
            rxBuf_q   <= rxBuf_d;
            txHold_q  <= txHold_d;
            divLow_q  <= divLow_d;
            div_q     <= div_d;
        end
    end

    assign rda     = rda_q;
    assign tbr     = tbr_q;
    assign tx_data = txHold_q;

    spart_baud_gen #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_baud_gen (
        .clk       (clk),
        .rst       (rst),
        .div_i     (div_d),
        .load_i    (wrDbh),
        .baud_en_o (baud_en)
    );

endmodule

// File: tb/tb_spart_bus_baud.sv
// Scoreboard bench for spart_bus_baud: expected tx and rx bytes are queued as stimulus is
// driven and popped when the DUT presents them on tx_data or the data bus.
module tb_spart_bus_baud;

    logic       clk = 1'b0;
    logic       rst;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       tbDrive;
    logic [7:0] tbData;
    logic       rda;
    logic       tbr;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       baud_en;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] txExpQ[$];
    logic [7:0] rxExpQ[$];

    localparam logic [1:0] A_BUF  = 2'b00;
    localparam logic [1:0] A_STAT = 2'b01;
    localparam logic [1:0] A_DBL  = 2'b10;
    localparam logic [1:0] A_DBH  = 2'b11;

    always #5 clk = ~clk;

    assign databus = tbDrive ? tbData : 8'hzz;

    spart_bus_baud dut (
        .clk      (clk),
        .rst      (rst),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .rda      (rda),
        .tbr      (tbr),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .baud_en  (baud_en)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; tbData = d; tbDrive = 1'b1;
        @(posedge clk);
        #1;
        iocs = 1'b0; tbDrive = 1'b0;
    endtask

    task automatic busRead(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1;
        d = databus;
        @(posedge clk);
        #1;
        iocs = 1'b0; iorw = 1'b0;
    endtask

    // The receive buffer holds one byte, so a new byte replaces any unread one in the model
    task automatic rxPulse(input logic [7:0] d);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = d;
        if (rxExpQ.size() > 0) void'(rxExpQ.pop_front());
        rxExpQ.push_back(d);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic waitBaud(input int bound, output int n, output bit found);
        n = 0;
        found = 1'b0;
        while (!found && n < bound) begin
            cycle(1);
            n++;
            found = baud_en;
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        int n;
        bit found;
        rst = 1'b1;
        cycle(3);
        compared++;
        if ({tbr, rda, tx_start, baud_en} !== 4'b1000) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got tbr,rda,start,baud=%b expected 1000", {tbr, rda, tx_start, baud_en});
        end
        compared++;
        if (tx_data !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data);
        end
        rst = 1'b0;
        busRead(A_STAT, d);
        compared++;
        if (d !== 8'h01) begin
            mismatched++;
            $display("[TB] FAIL reset_status: got %h expected 01", d);
        end
        busRead(A_DBL, d);
        compared++;
        if (d !== 8'h8B) begin
            mismatched++;
            $display("[TB] FAIL reset_div_low: got %h expected 8b", d);
        end
        busRead(A_DBH, d);
        compared++;
        if (d !== 8'h02) begin
            mismatched++;
            $display("[TB] FAIL reset_div_high: got %h expected 02", d);
        end
        waitBaud(1000, n, found);
        compared++;
        if (!found) begin
            mismatched++;
            $display("[TB] FAIL reset_baud_sync: no baud_en within %0d cycles", n);
        end
        waitBaud(1000, n, found);
        compared++;
        if (!found || n != 651) begin
            mismatched++;
            $display("[TB] FAIL reset_baud_period: got %0d expected 651", n);
        end
    endtask

    task automatic test_baud;
        logic [7:0] d;
        int n;
        bit found;
        busWrite(A_DBL, 8'hA3);
        busRead(A_DBL, d);
        compared++;
        if (d !== 8'h8B) begin
            mismatched++;
            $display("[TB] FAIL staging_not_active: got %h expected 8b", d);
        end
        busWrite(A_DBH, 8'h00);
        waitBaud(400, n, found);
        compared++;
        if (!found || n != 162) begin
            mismatched++;
            $display("[TB] FAIL baud_first_after_load: got %0d expected 162", n);
        end
        waitBaud(400, n, found);
        compared++;
        if (!found || n != 163) begin
            mismatched++;
            $display("[TB] FAIL baud_period_a3: got %0d expected 163", n);
        end
        busRead(A_DBL, d);
        compared++;
        if (d !== 8'hA3) begin
            mismatched++;
            $display("[TB] FAIL div_low_a3: got %h expected a3", d);
        end
        busRead(A_DBH, d);
        compared++;
        if (d !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL div_high_00: got %h expected 00", d);
        end
        for (int v = 1; v >= 0; v--) begin
            busWrite(A_DBL, 8'(v));
            busWrite(A_DBH, 8'h00);
            for (int k = 0; k < 2; k++) begin
                waitBaud(10, n, found);
                compared++;
                if (!found || n != 1) begin
                    mismatched++;
                    $display("[TB] FAIL baud_div%0d_every_cycle: got %0d expected 1", v, n);
                end
            end
        end
        busWrite(A_DBL, 8'hA3);
        busWrite(A_DBH, 8'h00);
    endtask

    task automatic waitTxStart(input string name);
        int k = 0;
        logic [7:0] exp;
        while (!tx_start && k < 12) begin
            cycle(1);
            k++;
        end
        compared++;
        if (!tx_start) begin
            mismatched++;
            $display("[TB] FAIL %s: no tx_start within %0d cycles", name, k);
        end else if (txExpQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL %s: unexpected tx_start with %h", name, tx_data);
        end else begin
            exp = txExpQ.pop_front();
            if (tx_data !== exp) begin
                mismatched++;
                $display("[TB] FAIL %s: got tx_data %h expected %h", name, tx_data, exp);
            end
        end
    endtask

    task automatic test_tx;
        int pulses;
        tx_busy = 1'b0;
        txExpQ.push_back(8'h55);
        busWrite(A_BUF, 8'h55);
        compared++;
        if (tbr !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL tx_tbr_clear: got %b expected 0", tbr);
        end
        busWrite(A_BUF, 8'hAA);
        waitTxStart("tx_first_byte");
        cycle(1);
        compared++;
        if ({tbr, tx_start} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL tx_after_start: got tbr,start=%b expected 10", {tbr, tx_start});
        end
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(1);
            if (tx_start) pulses++;
        end
        compared++;
        if (pulses != 0) begin
            mismatched++;
            $display("[TB] FAIL tx_dropped_write: got %0d extra pulses expected 0", pulses);
        end
        tx_busy = 1'b1;
        txExpQ.push_back(8'h33);
        busWrite(A_BUF, 8'h33);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(1);
            if (tx_start) pulses++;
        end
        compared++;
        if (pulses != 0 || tbr !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL tx_hold_while_busy: got pulses=%0d tbr=%b expected 0/0", pulses, tbr);
        end
        tx_busy = 1'b0;
        waitTxStart("tx_after_busy");
        cycle(4);
    endtask

    task automatic test_back_to_back;
        tx_busy = 1'b0;
        txExpQ.push_back(8'h11);
        busWrite(A_BUF, 8'h11);
        cycle(1);
        waitTxStart("b2b_first");
        txExpQ.push_back(8'h22);
        busWrite(A_BUF, 8'h22);
        compared++;
        if (tbr !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_accept: got tbr %b expected 0", tbr);
        end
        waitTxStart("b2b_second");
        compared++;
        if (txExpQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_queue_drain: got %0d left expected 0", txExpQ.size());
        end
        cycle(4);
    endtask

    task automatic test_rx;
        logic [7:0] d;
        logic [7:0] exp;
        rxPulse(8'h3C);
        compared++;
        if (rda !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rx_rda_set: got %b expected 1", rda);
        end
        busRead(A_STAT, d);
        compared++;
        if (d !== 8'h03) begin
            mismatched++;
            $display("[TB] FAIL rx_status: got %h expected 03", d);
        end
        busRead(A_BUF, d);
        exp = rxExpQ.pop_front();
        compared++;
        if (d !== exp) begin
            mismatched++;
            $display("[TB] FAIL rx_read_byte: got %h expected %h", d, exp);
        end
        compared++;
        if (rda !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rx_rda_clear: got %b expected 0", rda);
        end
        rxPulse(8'hA1);
        rxPulse(8'hB2);
        busRead(A_STAT, d);
        compared++;
        if (d !== 8'h07) begin
            mismatched++;
            $display("[TB] FAIL rx_overrun_status: got %h expected 07", d);
        end
        busRead(A_BUF, d);
        exp = rxExpQ.pop_front();
        compared++;
        if (d !== exp) begin
            mismatched++;
            $display("[TB] FAIL rx_overrun_byte: got %h expected %h", d, exp);
        end
        busRead(A_STAT, d);
        compared++;
        if (d !== 8'h01) begin
            mismatched++;
            $display("[TB] FAIL rx_overrun_clear: got %h expected 01", d);
        end
    endtask

    task automatic test_rx_collision;
        logic [7:0] d;
        logic [7:0] exp;
        rxPulse(8'h5A);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = A_BUF;
        rx_valid = 1'b1; rx_data = 8'hC3;
        #1;
        d = databus;
        exp = rxExpQ.pop_front();
        rxExpQ.push_back(8'hC3);
        compared++;
        if (d !== exp) begin
            mismatched++;
            $display("[TB] FAIL collide_old_byte: got %h expected %h", d, exp);
        end
        @(posedge clk);
        #1;
        iocs = 1'b0; iorw = 1'b0; rx_valid = 1'b0;
        busRead(A_STAT, d);
        compared++;
        if (d !== 8'h03) begin
            mismatched++;
            $display("[TB] FAIL collide_status: got %h expected 03", d);
        end
        busRead(A_BUF, d);
        exp = rxExpQ.pop_front();
        compared++;
        if (d !== exp) begin
            mismatched++;
            $display("[TB] FAIL collide_new_byte: got %h expected %h", d, exp);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        int pulses;
        busWrite(A_DBL, 8'hA3);
        busWrite(A_DBH, 8'h00);
        rxPulse(8'h77);
        tx_busy = 1'b1;
        busWrite(A_BUF, 8'h99);
        compared++;
        if ({tbr, rda} !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL mid_pre_reset: got tbr,rda=%b expected 01", {tbr, rda});
        end
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        rxExpQ.delete();
        compared++;
        if ({tbr, rda, tx_start} !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_flags: got tbr,rda,start=%b expected 100", {tbr, rda, tx_start});
        end
        busRead(A_DBL, d);
        compared++;
        if (d !== 8'h8B) begin
            mismatched++;
            $display("[TB] FAIL mid_div_low: got %h expected 8b", d);
        end
        busRead(A_DBH, d);
        compared++;
        if (d !== 8'h02) begin
            mismatched++;
            $display("[TB] FAIL mid_div_high: got %h expected 02", d);
        end
        tx_busy = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(1);
            if (tx_start) pulses++;
        end
        compared++;
        if (pulses != 0) begin
            mismatched++;
            $display("[TB] FAIL mid_no_stale_tx: got %0d pulses expected 0", pulses);
        end
        busWrite(A_DBH, 8'h00);
        busRead(A_DBL, d);
        compared++;
        if (d !== 8'h8B) begin
            mismatched++;
            $display("[TB] FAIL mid_staging_reset: got %h expected 8b", d);
        end
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = A_STAT; tbDrive = 1'b1; tbData = 8'h5A;
        #1;
        compared++;
        if (databus !== 8'h5A) begin
            mismatched++;
            $display("[TB] FAIL bus_release_write: got %h expected 5a", databus);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b1; ioaddr = A_BUF; tbData = 8'hC3;
        #1;
        compared++;
        if (databus !== 8'hC3) begin
            mismatched++;
            $display("[TB] FAIL bus_release_nocs: got %h expected c3", databus);
        end
        @(posedge clk);
        #1;
        tbDrive = 1'b0; iorw = 1'b0;
        busRead(A_STAT, d);
        compared++;
        if (d !== 8'h01) begin
            mismatched++;
            $display("[TB] FAIL stat_write_ignored: got %h expected 01", d);
        end
    endtask

    initial begin
        rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        tbDrive = 1'b0; tbData = 8'h00; tx_busy = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0;
        $display("[TB] starting spart_bus_baud bench");
        test_reset();
        test_baud();
        test_tx();
        test_back_to_back();
        test_rx();
        test_rx_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
